// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU input sequencer: FSM state codes and ALU opcodes.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_CALC = 3'd3,
    S_RES  = 3'd4
  } state_t;

  localparam logic [2:0] OP_SUMA  = 3'b000;
  localparam logic [2:0] OP_RESTA = 3'b001;
  localparam logic [2:0] OP_OR    = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_MULT  = 3'b100;

endpackage

// File: rtl/boton_pulso.sv
// Button conditioning: two-flop synchronizer plus a history flop giving a
// single-cycle pulse on each synchronized rising edge of the pin.
module boton_pulso (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic pulso
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= btn_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign pulso = r_s2 & ~r_s3;

endmodule

// File: rtl/alu_input_sequencer.sv
// Collects operand A, operand B and opcode from switches on enter presses,
// drives the ALU from registers and captures its result for the display.
module alu_input_sequencer
  import alu_seq_pkg::*;
#(
  parameter int n_bits = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [n_bits-1:0] switches,
  input  logic              btn_enter,
  input  logic              btn_clear,
  input  logic [n_bits-1:0] resultado_alu,
  input  logic              overflow_alu,
  output logic [n_bits-1:0] entrada_a,
  output logic [n_bits-1:0] entrada_b,
  output logic [2:0]        operacion,
  output logic [n_bits-1:0] resultado_reg,
  output logic              overflow_reg,
  output logic              resultado_valido,
  output logic [2:0]        estado
);

  logic w_enter;
  logic w_clear;

  boton_pulso u_enter (
    .clk    (clk),
    .reset  (reset),
    .btn_in (btn_enter),
    .pulso  (w_enter)
  );

  boton_pulso u_clear (
    .clk    (clk),
    .reset  (reset),
    .btn_in (btn_clear),
    .pulso  (w_clear)
  );

  state_t            r_state;
  logic [n_bits-1:0] r_a;
  logic [n_bits-1:0] r_b;
  logic [2:0]        r_op;
  logic [n_bits-1:0] r_res;
  logic              r_ovf;
  logic              r_valid;

  always_ff @(posedge clk) begin
    if (reset || w_clear) begin
      // Clear outranks a simultaneous enter pulse.
      r_state <= S_A;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_res   <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_A: if (w_enter) begin
          r_a     <= switches;
          r_state <= S_B;
        end
        S_B: if (w_enter) begin
          r_b     <= switches;
          r_state <= S_OP;
        end
        S_OP: if (w_enter) begin
          r_op    <= switches[2:0];
          r_state <= S_CALC;
        end
        S_CALC: begin
          r_res   <= resultado_alu;
          r_ovf   <= overflow_alu;
          r_valid <= 1'b1;
          r_state <= S_RES;
        end
        S_RES: if (w_enter) begin
          r_valid <= 1'b0;
          r_state <= S_A;
        end
        default: r_state <= S_A;
      endcase
    end
  end

  assign entrada_a        = r_a;
  assign entrada_b        = r_b;
  assign operacion        = r_op;
  assign resultado_reg    = r_res;
  assign overflow_reg     = r_ovf;
  assign resultado_valido = r_valid;
  assign estado           = r_state;

endmodule
